// File: rtl/relprime_controller.sv
// Finds the smallest m >= 2 coprime to an operand n by retrying
// subtractive-Euclid gcd(n, m) for m = 2, 3, ... until the gcd is 1.
module relprime_controller #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] register_value,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [2:0] {IDLE, LOAD, STEP, CHECK, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, a_nxt;
    logic [WIDTH-1:0] b, b_nxt;
    logic [WIDTH-1:0] m, m_nxt;
    logic [WIDTH-1:0] n_reg, n_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             error_nxt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            m     <= '0;
            n_reg <= '0;
            out   <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            m     <= m_nxt;
            n_reg <= n_nxt;
            out   <= out_nxt;
            error <= error_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        m_nxt     = m;
        n_nxt     = n_reg;
        out_nxt   = out;
        error_nxt = error;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    n_nxt     = register_value;
                    m_nxt     = WIDTH'(2);
                    error_nxt = 1'b0;
                    if (register_value == '0) begin
                        error_nxt = 1'b1;
                        out_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                a_nxt     = n_reg;
                b_nxt     = m;
                state_nxt = STEP;
            end
            // Subtractions are guarded by the magnitude compare, so never underflow.
            STEP: begin
                if (a == b)     state_nxt = CHECK;
                else if (a > b) a_nxt = a - b;
                else            b_nxt = b - a;
            end
            CHECK: begin
                if (a == WIDTH'(1)) begin
                    out_nxt   = m;
                    state_nxt = DONE;
                end else if (m == '1) begin
                    error_nxt = 1'b1;
                    out_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    m_nxt     = m + WIDTH'(1);
                    state_nxt = LOAD;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_relprime_controller.sv
// Randomized and directed bench for relprime_controller against a
// division-based Euclid reference model (result, error and latency).
module tb_relprime_controller;

    localparam int WIDTH  = 16;
    localparam int BUDGET = 40000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] rv = '0;
    logic             busy, done, error;
    logic [WIDTH-1:0] out;

    int nchk = 0;
    int nerr = 0;

    relprime_controller #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .RST_N(rst_n), .start(start), .register_value(rv),
        .busy(busy), .done(done), .error(error), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Euclid by division; sum of quotients equals the subtractive step count
    // including the final equality cycle.
    function automatic void euclid(input int x, input int y, output int g, output int sq);
        int t;
        sq = 0;
        while (y != 0) begin
            sq += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        g = x;
    endfunction

    // Cycles from the sampling edge until done is seen: per candidate m one
    // LOAD, the steps, one CHECK; plus the DONE cycle.
    function automatic void model(input int n, output int m, output int e, output int lat);
        int g, sq;
        m = 0; e = 1; lat = 1;
        if (n == 0) return;
        for (int c = 2; c <= 65535; c++) begin
            euclid(n, c, g, sq);
            lat += 2 + sq;
            if (g == 1) begin
                m = c; e = 0;
                return;
            end
        end
    endfunction

    task automatic launch(input logic [WIDTH-1:0] n);
        @(negedge clk);
        start = 1'b1;
        rv    = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle `lat`; returns when done is seen.
    task automatic wait_done(inout int lat);
        while (!done && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [WIDTH-1:0] n);
        int em, ee, el, lat;
        model(int'(n), em, ee, el);
        launch(n);
        lat = 1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(el));
        chk({tag, "_out"}, 32'(out), 32'(em));
        chk({tag, "_err"}, 32'(error), 32'(ee));
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int ndone, lat, gap;
        logic [WIDTH-1:0] held;

        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        #4 rst_n = 1'b1;

        run_check("n14", 16'd14);
        run_check("n1", 16'd1);
        run_check("n0", 16'd0);
        run_check("n65535", 16'hFFFF);

        // out/error hold in IDLE while register_value wanders
        held = out;
        rv = 16'd6;
        repeat (5) @(negedge clk);
        chk("hold_out", 32'(out), 32'(held));

        for (int i = 0; i < 12; i++)
            run_check("rnd", 16'($urandom_range(0, 1023)));

        // Start re-pulsed mid-run must be ignored and not queued.
        begin
            int em, ee, el;
            model(30, em, ee, el);
            launch(16'd30);
            lat = 1;
            @(negedge clk); lat++;
            start = 1'b1; rv = 16'd5;
            @(negedge clk); lat++;
            start = 1'b0;
            wait_done(lat);
            chk("mid_lat", 32'(lat), 32'(el));
            chk("mid_out", 32'(out), 32'(em));
            ndone = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("mid_nodone", 32'(ndone), 32'd0);
        end

        // Async reset during STEP of n=14
        launch(16'd14);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'd0);
        chk("arst_flags", {29'd0, busy, done, error}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("arst_quiet", 32'(ndone), 32'd0);
        run_check("n14b", 16'd14);

        // start held high: back-to-back runs, one IDLE cycle between them
        @(negedge clk);
        start = 1'b1; rv = 16'd1;
        lat = 0;
        wait_done(lat);
        gap = 0;
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);
        gap = 1;
        wait_done(gap);
        chk("b2b_gap", 32'(gap), 32'd6);
        chk("b2b_out", 32'(out), 32'd2);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("b2b_end", {30'd0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
